// File: rtl/bsg_mcl_to_axil_rx_pkg.sv
// Shared definitions for the manycore-link receive path: AXI-Lite register
// offsets, FIFO geometry, ISR bit position and the FSM state encodings used
// by bsg_mcl_to_axil_rx.
package bsg_mcl_to_axil_rx_pkg;

  localparam int unsigned axil_data_width_lp = 32;
  localparam int unsigned rcv_fifo_els_p     = 64;
  localparam int unsigned fifo_rlr_words_lp  = 4;
  localparam int unsigned FIFO_ISR_RC_BIT_p  = 26;

  localparam logic [7:0] ofs_isr_lp  = 8'h00;
  localparam logic [7:0] ofs_rdfo_lp = 8'h1C;
  localparam logic [7:0] ofs_rdr_lp  = 8'h20;
  localparam logic [7:0] ofs_rlr_lp  = 8'h24;

  localparam logic [1:0] axil_resp_okay_lp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_lp = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} rd_state_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;

endpackage

// File: rtl/bsg_mcl_to_axil_rx_fifo.sv
// Small 1-read/1-write packet FIFO.
//   clk_i/reset_i : clock, synchronous active-high reset (empties the FIFO)
//   v_i/data_i/ready_o : enqueue side, valid-ready; ready_o low when full or in reset
//   v_o/data_o/yumi_i  : dequeue side; data_o is the head, yumi_i pops it
//   count_o            : number of stored elements
module bsg_fifo_1r1w_small #(
  parameter int unsigned els_p   = 64,
  parameter int unsigned width_p = 128
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p+1);
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, rptr_q;
  logic [cnt_w_lp-1:0] count_q;
  logic                enq, deq;

  assign ready_o = ~reset_i & (count_q != els_lp);
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wptr_q <= (wptr_q == ptr_w_lp'(els_p-1)) ? '0 : wptr_q + 1'b1;
      if (deq) rptr_q <= (rptr_q == ptr_w_lp'(els_p-1)) ? '0 : rptr_q + 1'b1;
      if (enq & ~deq)      count_q <= count_q + 1'b1;
      else if (deq & ~enq) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/bsg_mcl_to_axil_rx.sv
// Host-side receive path of the manycore link. Buffers 128-bit packets and
// exposes them as an AXI-Lite read FIFO (ISR 0x00, RDFO 0x1C, RDR 0x20, RLR 0x24),
// one 32-bit word per RDR read, word 0 = bits [31:0] first.
//   clk_i/reset_i       : clock, synchronous active-high reset
//   pkt_v_i/pkt_i/pkt_ready_o : incoming packet valid-ready handshake
//   s_axil_aw*/w*/b*    : AXI-Lite write channel (only ISR W1C has effect)
//   s_axil_ar*/r*       : AXI-Lite read channel, one outstanding read
//   rcv_vacancy_o       : free packet slots in the receive FIFO
module bsg_mcl_to_axil_rx
  import bsg_mcl_to_axil_rx_pkg::*;
#(
  parameter int unsigned fifo_els_p        = rcv_fifo_els_p,
  parameter int unsigned pkt_width_p       = 128,
  parameter int unsigned axil_addr_width_p = 32
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               pkt_v_i,
  input  logic [pkt_width_p-1:0]             pkt_i,
  output logic                               pkt_ready_o,
  input  logic [axil_addr_width_p-1:0]       s_axil_awaddr_i,
  input  logic                               s_axil_awvalid_i,
  output logic                               s_axil_awready_o,
  input  logic [31:0]                        s_axil_wdata_i,
  input  logic [3:0]                         s_axil_wstrb_i,
  input  logic                               s_axil_wvalid_i,
  output logic                               s_axil_wready_o,
  output logic [1:0]                         s_axil_bresp_o,
  output logic                               s_axil_bvalid_o,
  input  logic                               s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0]       s_axil_araddr_i,
  input  logic                               s_axil_arvalid_i,
  output logic                               s_axil_arready_o,
  output logic [31:0]                        s_axil_rdata_o,
  output logic [1:0]                         s_axil_rresp_o,
  output logic                               s_axil_rvalid_o,
  input  logic                               s_axil_rready_i,
  output logic [$clog2(fifo_els_p+1)-1:0]    rcv_vacancy_o
);

  localparam int unsigned cnt_w_lp = $clog2(fifo_els_p+1);

  logic                   fifo_v, fifo_pop, enq;
  logic [pkt_width_p-1:0] fifo_data;
  logic [cnt_w_lp-1:0]    fifo_count;

  bsg_fifo_1r1w_small #(.els_p(fifo_els_p), .width_p(pkt_width_p)) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (pkt_v_i),
    .data_i  (pkt_i),
    .ready_o (pkt_ready_o),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (fifo_pop),
    .count_o (fifo_count)
  );

  assign enq           = pkt_v_i & pkt_ready_o;
  assign rcv_vacancy_o = cnt_w_lp'(fifo_els_p) - fifo_count;

  // ---------------- read path ----------------
  rd_state_e   rd_state_q;
  logic        arready_q, rvalid_q, rdr_hit_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d, word_idx_q;
  logic        ar_hs, r_hs, rdr_sel;
  logic        isr_rc_q;

  assign s_axil_arready_o = arready_q & ~reset_i;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
  assign ar_hs   = s_axil_arready_o & s_axil_arvalid_i;
  assign r_hs    = (rd_state_q == R_RESP) & s_axil_rready_i;
  assign rdr_sel = (s_axil_araddr_i[7:0] == ofs_rdr_lp);
  // Pop happens on the R handshake of the last word of the head packet.
  assign fifo_pop = r_hs & rdr_hit_q & (word_idx_q == 2'd3);

  always_comb begin
    rdata_d = '0;
    rresp_d = axil_resp_okay_lp;
    case (s_axil_araddr_i[7:0])
      ofs_isr_lp:  rdata_d[FIFO_ISR_RC_BIT_p] = isr_rc_q;
      ofs_rdfo_lp: rdata_d = 32'({fifo_count, 2'b00}) - 32'(word_idx_q);
      ofs_rdr_lp:  begin
        if (fifo_v) rdata_d = fifo_data[32*word_idx_q +: 32];
        else        rresp_d = axil_resp_slverr_lp;
      end
      ofs_rlr_lp:  rdata_d = fifo_v ? 32'(fifo_rlr_words_lp*4) : '0;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdr_hit_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= axil_resp_okay_lp;
      word_idx_q <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            rd_state_q <= R_RESP;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rdr_hit_q  <= rdr_sel & fifo_v;
          end
        end
        R_RESP: begin
          if (s_axil_rready_i) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdr_hit_q  <= 1'b0;
            // 2-bit index wraps 3 -> 0 alongside the head pop.
            if (rdr_hit_q) word_idx_q <= word_idx_q + 1'b1;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write path ----------------
  wr_state_e wr_state_q;
  logic      bvalid_q, w_hs, isr_clr;

  assign w_hs = (wr_state_q == W_IDLE) & s_axil_awvalid_i & s_axil_wvalid_i & ~reset_i;
  assign s_axil_awready_o = w_hs;
  assign s_axil_wready_o  = w_hs;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = axil_resp_okay_lp;
  assign isr_clr = w_hs & (s_axil_awaddr_i[7:0] == ofs_isr_lp)
                 & s_axil_wdata_i[FIFO_ISR_RC_BIT_p] & s_axil_wstrb_i[3];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_state_q <= W_IDLE;
      bvalid_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (w_hs) begin
          wr_state_q <= W_RESP;
          bvalid_q   <= 1'b1;
        end
        W_RESP: if (s_axil_bready_i) begin
          wr_state_q <= W_IDLE;
          bvalid_q   <= 1'b0;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Enqueue has priority over a coincident W1C so no arrival is lost.
  always_ff @(posedge clk_i) begin
    if (reset_i)      isr_rc_q <= 1'b0;
    else if (enq)     isr_rc_q <= 1'b1;
    else if (isr_clr) isr_rc_q <= 1'b0;
  end

  logic unused_bits;
  assign unused_bits = ^{s_axil_awaddr_i[axil_addr_width_p-1:8],
                         s_axil_araddr_i[axil_addr_width_p-1:8],
                         s_axil_wstrb_i[2:0], s_axil_wdata_i[31:27],
                         s_axil_wdata_i[25:0]};

endmodule
